// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler that time-shares one external
// combinational multiplier among NREQ requesters. Two-stage pipeline:
// operand stage (drives the multiplier) and result stage (response channel).
module mult_share_sched #(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int ID_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_x,
   input  logic [NREQ*W-1:0] req_y,
   output logic [NREQ-1:0]   req_ready,
   output logic [W-1:0]      mul_x,
   output logic [W-1:0]      mul_y,
   input  logic [2*W-1:0]    mul_o,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [2*W-1:0]    rsp_prod,
   output logic              idle
);

   // operand stage
   logic              r_op_v;
   logic [W-1:0]      r_op_x;
   logic [W-1:0]      r_op_y;
   logic [ID_W-1:0]   r_op_id;
   // result stage
   logic              r_res_v;
   logic [2*W-1:0]    r_res_prod;
   logic [ID_W-1:0]   r_res_id;
   // round-robin pointer: index searched first
   logic [ID_W-1:0]   r_ptr;

   logic              w_res_free;
   logic              w_op_free;
   logic              w_accept;
   logic              w_advance;
   logic              w_found;
   logic [ID_W-1:0]   w_win;
   logic [ID_W-1:0]   w_idx;
   logic [W-1:0]      w_sel_x;
   logic [W-1:0]      w_sel_y;

   // A stage can take new data when empty or when its content leaves this cycle
   assign w_res_free = !r_res_v || rsp_ready;
   assign w_op_free  = !r_op_v || w_res_free;
   assign w_accept   = w_found && w_op_free;
   assign w_advance  = r_op_v && w_res_free;

   // Round-robin search from r_ptr; index arithmetic wraps because NREQ is 2**ID_W
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      w_sel_x = '0;
      w_sel_y = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = r_ptr + ID_W'(k);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
            w_sel_x = req_x[int'(w_idx)*W +: W];
            w_sel_y = req_y[int'(w_idx)*W +: W];
         end
      end
   end

   // One-hot grant, only when the operand stage can accept
   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_win] = 1'b1;
      end
   end

   // Operand stage and pointer: load winner, otherwise drain when it advances
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_v  <= 1'b0;
         r_op_x  <= '0;
         r_op_y  <= '0;
         r_op_id <= '0;
         r_ptr   <= '0;
      end else if (w_accept) begin
         r_op_v  <= 1'b1;
         r_op_x  <= w_sel_x;
         r_op_y  <= w_sel_y;
         r_op_id <= w_win;
         r_ptr   <= w_win + ID_W'(1);
      end else if (w_advance) begin
         r_op_v  <= 1'b0;
      end
   end

   // Result stage: capture the multiplier output, clear once consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_v    <= 1'b0;
         r_res_prod <= '0;
         r_res_id   <= '0;
      end else if (w_advance) begin
         r_res_v    <= 1'b1;
         r_res_prod <= mul_o;
         r_res_id   <= r_op_id;
      end else if (rsp_ready) begin
         r_res_v    <= 1'b0;
      end
   end

   // Multiplier operands come straight from the operand registers
   assign mul_x     = r_op_x;
   assign mul_y     = r_op_y;
   assign rsp_valid = r_res_v;
   assign rsp_prod  = r_res_prod;
   assign rsp_id    = r_res_id;
   assign idle      = !r_op_v && !r_res_v;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: directed scenarios followed by random traffic,
// every cycle compared with a transaction-level queue model.
module tb_mult_share_sched;
   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int ID_W = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_x;
   logic [NREQ*W-1:0] req_y;
   logic [NREQ-1:0]   req_ready;
   logic [W-1:0]      mul_x;
   logic [W-1:0]      mul_y;
   logic [2*W-1:0]    mul_o;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [2*W-1:0]    rsp_prod;
   logic              idle;

   always #5 clk = ~clk;

   // the shared combinational multiplier
   assign mul_o = mul_x * mul_y;

   mult_share_sched #(.NREQ(NREQ), .W(W), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
      .mul_x(mul_x), .mul_y(mul_y), .mul_o(mul_o),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_prod(rsp_prod), .idle(idle)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int sx [NREQ];
   int sy [NREQ];
   // model: in-flight transactions in accept order, whether the oldest has
   // reached the response channel, and the round-robin start index
   int m_q_id [$];
   int m_q_prod [$];
   bit m_res;
   int m_ptr;
   // responses actually handed over by the DUT
   int log_id [$];
   int log_prod [$];
   logic [NREQ-1:0] last_grant;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_x[i*W +: W] = W'(sx[i]);
         req_y[i*W +: W] = W'(sy[i]);
      end
   endtask

   task automatic log_clear();
      log_id.delete();
      log_prod.delete();
   endtask

   // One clock: called at a negedge with inputs already driven.
   task automatic cycle();
      int win;
      bit acc;
      bit cons;
      logic [NREQ-1:0] exp_rdy;
      #1;
      win = -1;
      for (int k = 0; k < NREQ; k++)
         if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      acc = (win >= 0) && ((m_q_id.size() < 2) || rsp_ready);
      exp_rdy = '0;
      if (acc) exp_rdy[win] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, m_res);
      chk("idle", idle, m_q_id.size() == 0);
      if (m_res) begin
         chk("rsp_id", rsp_id, m_q_id[0]);
         chk("rsp_prod", rsp_prod, m_q_prod[0]);
      end
      last_grant = req_ready;
      cons = rsp_valid && rsp_ready;
      if (cons) begin
         log_id.push_back(int'(rsp_id));
         log_prod.push_back(int'(rsp_prod));
      end
      @(posedge clk);
      if (m_res && rsp_ready) begin
         void'(m_q_id.pop_front());
         void'(m_q_prod.pop_front());
         m_res = 1'b0;
      end
      if (!m_res && m_q_id.size() > 0) m_res = 1'b1;
      if (acc) begin
         m_q_id.push_back(win);
         m_q_prod.push_back(sx[win] * sy[win]);
         m_ptr = (win + 1) % NREQ;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      req_valid = '0;
      rsp_ready = 1'b1;
      while (m_q_id.size() > 0 && n < 50) begin
         cycle();
         n++;
      end
      chk("drain_bound", n < 50, 1);
      cycle();
   endtask

   // Asynchronous reset asserted mid-cycle, released on a falling edge.
   task automatic do_reset();
      req_valid = '0;
      rsp_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_idle", idle, 1);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_prod", rsp_prod, 0);
      chk("rst_mul_x", mul_x, 0);
      chk("rst_mul_y", mul_y, 0);
      m_q_id.delete();
      m_q_prod.delete();
      m_res = 1'b0;
      m_ptr = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cx [4];
      int cy [4];
      rst_n = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin sx[i] = 0; sy[i] = 0; end
      apply_ops();
      @(negedge clk);
      do_reset();

      // streaming from reset: grants 0,1,2,3,0,... back-to-back
      log_clear();
      for (int i = 0; i < NREQ; i++) begin sx[i] = i + 1; sy[i] = 2; end
      apply_ops();
      rsp_ready = 1'b1;
      req_valid = '1;
      repeat (8) cycle();
      drain();
      chk("t2_count", log_id.size(), 8);
      for (int i = 0; i < 4; i++) begin
         chk("t2_id", log_id[i], i);
         chk("t2_prod", log_prod[i], 2 * (i + 1));
      end

      // single request from requester 2
      log_clear();
      sx[2] = 3; sy[2] = 5;
      apply_ops();
      req_valid = 4'b0100;
      cycle();
      chk("t1_grant", last_grant, 4'b0100);
      drain();
      chk("t1_count", log_id.size(), 1);
      chk("t1_id", log_id[0], 2);
      chk("t1_prod", log_prod[0], 15);

      // stream with back-pressure; pointer left at 3 by the previous step
      log_clear();
      for (int i = 0; i < NREQ; i++) begin sx[i] = i + 1; sy[i] = 2; end
      apply_ops();
      rsp_ready = 1'b1;
      req_valid = '1;
      cycle();
      chk("t3_first_grant", last_grant, 4'b1000);
      cycle();
      rsp_ready = 1'b0;
      repeat (3) begin
         cycle();
         chk("t3_stall_grant", last_grant, 0);
      end
      rsp_ready = 1'b1;
      repeat (6) cycle();
      drain();
      chk("t3_count", log_id.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("t3_id", log_id[i], (3 + i) % 4);
         chk("t3_prod", log_prod[i], 2 * (((3 + i) % 4) + 1));
      end

      // corner operands
      log_clear();
      cx[0] = 15; cy[0] = 15;
      cx[1] = 0;  cy[1] = 9;
      cx[2] = 15; cy[2] = 1;
      cx[3] = 1;  cy[3] = 15;
      for (int p = 0; p < 4; p++) begin
         sx[0] = cx[p]; sy[0] = cy[p];
         apply_ops();
         req_valid = 4'b0001;
         cycle();
      end
      drain();
      chk("t4_count", log_prod.size(), 4);
      chk("t4_15x15", log_prod[0], 225);
      chk("t4_0x9", log_prod[1], 0);
      chk("t4_15x1", log_prod[2], 15);
      chk("t4_1x15", log_prod[3], 15);

      // fairness: after requester 1, 3 is preferred over 0
      req_valid = 4'b0010;
      cycle();
      chk("t5_g1", last_grant, 4'b0010);
      req_valid = 4'b1001;
      cycle();
      chk("t5_g3", last_grant, 4'b1000);
      req_valid = 4'b0001;
      cycle();
      chk("t5_g0", last_grant, 4'b0001);
      drain();

      // reset with both stages occupied
      for (int i = 0; i < NREQ; i++) begin sx[i] = i + 1; sy[i] = 3; end
      apply_ops();
      req_valid = '1;
      rsp_ready = 1'b0;
      repeat (3) cycle();
      #1;
      chk("t6_full_valid", rsp_valid, 1);
      chk("t6_full_idle", idle, 0);
      log_clear();
      do_reset();
      sx[0] = 2; sy[0] = 7;
      apply_ops();
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      cycle();
      drain();
      repeat (2) cycle();
      chk("t6_count", log_id.size(), 1);
      chk("t6_id", log_id[0], 0);
      chk("t6_prod", log_prod[0], 14);

      // random traffic
      repeat (400) begin
         for (int i = 0; i < NREQ; i++) begin
            sx[i] = int'($urandom_range(0, 15));
            sy[i] = int'($urandom_range(0, 15));
         end
         apply_ops();
         req_valid = NREQ'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
